cdc_hk_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the write side of one `cdc_hk` handshake channel among NREQ requesters in the `wclk` domain. Each cycle it selects one pending requester, registers that requester's payload, and presents it on the channel's `wr_vld`/`wr_rdy` handshake. It holds `wr_vld` and the payload stable until `cdc_hk` accepts them. The block sits directly in front of `cdc_hk` and drives that block's write-domain inputs.

---
 rtl/cdc_hk_arb.sv | 140 ++++++++++++++
 tb/tb_cdc_hk_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hk_arb.sv
// cdc_hk_arb: round-robin arbiter that shares the write side of one cdc_hk
// handshake channel among NREQ requesters in the wclk domain.
//
// A one-entry output register holds wr_vld/wr_data/gnt_id until cdc_hk accepts
// them. A new payload is accepted whenever that register is empty or is being
// drained in the same cycle, so back-to-back transfers have no bubble.
//
// Ports:
//   wclk, wr_rst         write-domain clock, synchronous active-high reset
//   req_vld  [NREQ]      per-requester valid
//   req_data [NREQ*DW]   payloads, requester i on bits [i*DW +: DW]
//   req_rdy  [NREQ]      per-requester accept (combinational, one-hot or zero)
//   wr_vld, wr_data      registered payload towards cdc_hk
//   wr_rdy               accept from cdc_hk
//   gnt_id               index of the requester whose payload is on wr_data
//   busy                 equals wr_vld
//   xfer_cnt [CW]        completed downstream transfers, wraps modulo 2^CW
//
// Optional feature macro: CDC_HK_ARB_PRIO0_EN
//   defined   -> requester 0 has fixed priority and leaves ptr unchanged;
//                requesters 1..NREQ-1 round-robin among themselves
//   undefined -> pure round-robin over all requesters

module cdc_hk_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 16
) (
    input  logic                      wclk,
    input  logic                      wr_rst,
    input  logic [NREQ-1:0]           req_vld,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           req_rdy,
    output logic                      wr_vld,
    output logic [DW-1:0]             wr_data,
    input  logic                      wr_rdy,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output logic [CW-1:0]             xfer_cnt
);

    localparam int unsigned IW = $clog2(NREQ);

`ifdef CDC_HK_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   ptr_nxt;
    logic [DW-1:0]   sel_data;
    logic            found;
    logic            slot_free;
    logic            accept;
    logic            drain;

    assign wr_vld    = (state == FULL);
    assign busy      = wr_vld;
    assign slot_free = !wr_vld || wr_rdy;
    assign drain     = wr_vld && wr_rdy;
    assign accept    = |req_rdy;

    // Winner search starting at ptr; with PRIO0, requester 0 pre-empts the
    // search and is excluded from the rotating part.
    always_comb begin : p_search
        int idx;
        idx      = 0;
        found    = 1'b0;
        win      = '0;
        sel_data = '0;
        if (PRIO0 && req_vld[0]) begin
            found    = 1'b1;
            win      = '0;
            sel_data = req_data[DW-1:0];
        end
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(ptr) + k) % int'(NREQ);
            if (!found && req_vld[idx] && !(PRIO0 && idx == 0)) begin
                found    = 1'b1;
                win      = IW'(idx);
                sel_data = req_data[idx*int'(DW) +: DW];
            end
        end
    end

    // One-hot accept, suppressed during reset and while the output is stalled.
    always_comb begin
        req_rdy = '0;
        if (!wr_rst && slot_free && found) begin
            req_rdy[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_nxt = (int'(win) == int'(NREQ) - 1) ? '0 : IW'(int'(win) + 1);
    end

    // Output register occupancy.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (drain && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wr_rst) begin
            state    <= EMPTY;
            wr_data  <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            xfer_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_data <= sel_data;
                gnt_id  <= win;
                // A fixed-priority grant to requester 0 must not disturb the rotation.
                if (!(PRIO0 && win == '0)) begin
                    ptr <= ptr_nxt;
                end
            end
            if (drain) begin
                xfer_cnt <= xfer_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdc_hk_arb.sv
// Directed self-checking bench for cdc_hk_arb (NREQ=4, DW=8, CW=4).
module tb_cdc_hk_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 4;

    logic              wclk;
    logic              wr_rst;
    logic [NREQ-1:0]   req_vld;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_rdy;
    logic              wr_vld;
    logic [DW-1:0]     wr_data;
    logic              wr_rdy;
    logic [1:0]        gnt_id;
    logic              busy;
    logic [CW-1:0]     xfer_cnt;

    int checks;
    int errors;

    cdc_hk_arb #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
        .wclk    (wclk),
        .wr_rst  (wr_rst),
        .req_vld (req_vld),
        .req_data(req_data),
        .req_rdy (req_rdy),
        .wr_vld  (wr_vld),
        .wr_data (wr_data),
        .wr_rdy  (wr_rdy),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .xfer_cnt(xfer_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst  = 1'b1;
        req_vld = '0;
        step();
        wr_rst = 1'b0;
    endtask

    task automatic test_reset();
        wr_rst   = 1'b1;
        wr_rdy   = 1'b1;
        req_vld  = 4'b1111;
        req_data = 32'h13_12_11_10;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (wr_vld !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_wr_vld cyc %0d got %b/%b exp 0", c, wr_vld, busy);
            end
            checks++;
            if (req_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL reset_req_rdy cyc %0d got %b exp 0000", c, req_rdy);
            end
            checks++;
            if (xfer_cnt !== 4'd0 || gnt_id !== 2'd0 || wr_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_regs cyc %0d cnt %0d gnt %0d data %h exp 0", c, xfer_cnt, gnt_id, wr_data);
            end
        end
        wr_rst = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL first_rdy got %b exp 0001", req_rdy);
        end
        step();
        req_vld = '0;
        #1;
        checks++;
        if (wr_vld !== 1'b1 || gnt_id !== 2'd0 || wr_data !== 8'h10) begin
            errors++;
            $display("FAIL first_grant vld %b gnt %0d data %h exp 1/0/10", wr_vld, gnt_id, wr_data);
        end
        step();
        checks++;
        if (wr_vld !== 1'b0 || xfer_cnt !== 4'd1) begin
            errors++;
            $display("FAIL first_drain vld %b cnt %0d exp 0/1", wr_vld, xfer_cnt);
        end
    endtask

    // Continues from test_reset: ptr=1, xfer_cnt=1.
    task automatic test_single();
        req_data = 32'h00_A5_00_00;
        req_vld  = 4'b0100;
        #1;
        checks++;
        if (req_rdy !== 4'b0100) begin
            errors++;
            $display("FAIL single_rdy got %b exp 0100", req_rdy);
        end
        step();
        req_vld = '0;
        #1;
        checks++;
        if (wr_vld !== 1'b1 || wr_data !== 8'hA5 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL single_out vld %b data %h gnt %0d exp 1/a5/2", wr_vld, wr_data, gnt_id);
        end
        step();
        checks++;
        if (xfer_cnt !== 4'd2 || wr_vld !== 1'b0 || wr_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_drain cnt %0d vld %b data %h exp 2/0/a5", xfer_cnt, wr_vld, wr_data);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_g;
        do_reset();
        wr_rdy   = 1'b1;
        req_data = 32'h13_12_11_10;
        req_vld  = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            exp_g = 2'(c % 4);
            checks++;
            if (wr_vld !== 1'b1 || gnt_id !== exp_g || wr_data !== (8'h10 + 8'(exp_g))) begin
                errors++;
                $display("FAIL rotation cyc %0d vld %b gnt %0d data %h exp gnt %0d", c, wr_vld, gnt_id, wr_data, exp_g);
            end
        end
        req_vld = '0;
        step();
        checks++;
        if (xfer_cnt !== 4'd5 || wr_vld !== 1'b0) begin
            errors++;
            $display("FAIL rotation_cnt cnt %0d vld %b exp 5/0", xfer_cnt, wr_vld);
        end
    endtask

    task automatic test_stall();
        do_reset();
        wr_rdy   = 1'b0;
        req_data = 32'h00_00_22_11;
        req_vld  = 4'b0011;
        step();
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (req_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL stall_rdy cyc %0d got %b exp 0000", c, req_rdy);
            end
            step();
            checks++;
            if (wr_vld !== 1'b1 || gnt_id !== 2'd0 || wr_data !== 8'h11 || xfer_cnt !== 4'd0) begin
                errors++;
                $display("FAIL stall_hold cyc %0d vld %b gnt %0d data %h cnt %0d", c, wr_vld, gnt_id, wr_data, xfer_cnt);
            end
        end
        wr_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL stall_release_rdy got %b exp 0010", req_rdy);
        end
        step();
        req_vld = '0;
        #1;
        checks++;
        if (wr_vld !== 1'b1 || gnt_id !== 2'd1 || wr_data !== 8'h22 || xfer_cnt !== 4'd1) begin
            errors++;
            $display("FAIL stall_release vld %b gnt %0d data %h cnt %0d exp 1/1/22/1", wr_vld, gnt_id, wr_data, xfer_cnt);
        end
        step();
        checks++;
        if (wr_vld !== 1'b0 || xfer_cnt !== 4'd2) begin
            errors++;
            $display("FAIL stall_drain vld %b cnt %0d exp 0/2", wr_vld, xfer_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wr_rdy   = 1'b1;
        req_data = 32'h00_00_00_5A;
        req_vld  = 4'b0001;
        for (int c = 0; c < 17; c++) begin
            step();
            if (c == 15) begin
                checks++;
                if (xfer_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL wrap_mid got %0d exp 15", xfer_cnt);
                end
            end
        end
        req_vld = '0;
        step();
        checks++;
        if (xfer_cnt !== 4'd1 || wr_vld !== 1'b0) begin
            errors++;
            $display("FAIL wrap_cnt cnt %0d vld %b exp 1/0", xfer_cnt, wr_vld);
        end
    endtask

    task automatic test_prio0();
        logic [1:0] exp_g;
        do_reset();
        wr_rdy   = 1'b1;
        req_data = 32'h13_12_11_10;
        req_vld  = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (wr_vld !== 1'b1 || gnt_id !== 2'd0) begin
                errors++;
                $display("FAIL prio0_fixed cyc %0d vld %b gnt %0d exp 1/0", c, wr_vld, gnt_id);
            end
        end
        req_vld = 4'b1110;
        for (int c = 0; c < 3; c++) begin
            step();
            exp_g = 2'(c + 1);
            checks++;
            if (wr_vld !== 1'b1 || gnt_id !== exp_g) begin
                errors++;
                $display("FAIL prio0_rotate cyc %0d vld %b gnt %0d exp 1/%0d", c, wr_vld, gnt_id, exp_g);
            end
        end
        req_vld = '0;
        step();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_rst   = 1'b1;
        wr_rdy   = 1'b1;
        req_vld  = '0;
        req_data = '0;
        test_reset();
        test_single();
`ifdef CDC_HK_ARB_PRIO0_EN
        test_prio0();
`else
        test_rotation();
        test_stall();
`endif
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
